uart_tx: RTL
============

# uart_tx

Serial UART transmitter for the MIPS system's I/O path. It takes one byte per valid/ready handshake and shifts it out as a standard 8N1 frame: start bit, 8 data bits LSB first, stop bit. An optional parity bit can be compiled in. Bit timing comes from an internal free-running bit-period divider of the same form as the system's 8-bit baud counter, so the transmitter needs no external tick.

## Interface
- `CLKS_PER_BIT`, default 256: clock cycles per serial bit. Legal range is 2..256. The divider is 8 bits wide and counts 0..CLKS_PER_BIT-1.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `tx_data`  in  8  byte to send; sampled only on the accept edge.
- `tx_valid`  in  1  requester has a byte on `tx_data`.
- `tx_ready`  out  1  transmitter is idle and can accept a byte.
- `tx`  out  1  serial line; high when idle.
- `busy`  out  1  a frame is in progress; equal to `~tx_ready`.
- `bit_tick`  out  1  one-cycle pulse in the last cycle of every bit period.

## Operation
- Reset values: `tx`=1, `tx_ready`=1, `busy`=0, `bit_tick`=0, state IDLE, divider 0, shift register 0.
- Accept rule: a byte is accepted on a rising edge where `tx_valid && tx_ready`. On that edge the block latches `tx_data`, clears the divider and enters START. While not in IDLE, `tx_valid` and `tx_data` are ignored.
- Divider: counts 0..CLKS_PER_BIT-1 and wraps to 0. `bit_tick` is high when the divider equals CLKS_PER_BIT-1. A state advances only on the edge where `bit_tick`=1. In IDLE the divider is held at 0.
- States and outputs:
  - IDLE: `tx`=1, `tx_ready`=1.
  - START: `tx`=0.
  - DATA: `tx` = shift register bit 0. Shift right on each `bit_tick`. A 3-bit index counts 0..7, and the state leaves DATA after the tick on index 7.
  - PARITY: present only when compiled in; see Configuration.
  - STOP: `tx`=1.
- Transitions: IDLE→START on accept; START→DATA; DATA→DATA ×7, then →PARITY or →STOP; PARITY→STOP; STOP→IDLE.
- `tx` comes from a flop, not from combinational logic.
- Reset mid-frame: the frame is aborted immediately. `tx` goes to 1 and all outputs return to reset values. The byte is discarded and not retransmitted.
- With CLKS_PER_BIT=256 the divider wraps 255→0 naturally. No value outside 0..CLKS_PER_BIT-1 is ever reached.

## Timing
- Let C = CLKS_PER_BIT, and let edge A be the accept edge.
- `tx_ready` and `busy` change on edge A, i.e. `tx_ready` is low from the cycle after A.
- Start bit: `tx`=0 for cycles A+1 .. A+C.
- Data bit i (i = 0..7): `tx` = data[i] for cycles A+1+(i+1)C .. A+(i+2)C.
- Stop bit: cycles A+1+9C .. A+10C. Frame length is 10C cycles without parity, 11C with parity.
- `tx_ready` returns to 1 in cycle A+10C+1 (A+11C+1 with parity).
- Next accept: earliest on edge A+10C+1. Back-to-back frames therefore have no extra idle bit, but at least one cycle passes between frames.
- `bit_tick` pulses exactly 10 times per frame (11 with parity), at cycles A+kC for k=1..10.

## Configuration
- `UART_TX_PARITY_EN`:
  - When defined, a PARITY state is inserted between DATA and STOP. It lasts C cycles and drives `tx` = ^data, which is even parity over the 8 latched bits.
  - When undefined, PARITY logic and state are absent and DATA goes directly to STOP.

## Test plan
- Reset, then hold idle: `tx`=1, `tx_ready`=1, `busy`=0, `bit_tick`=0 for 50 cycles.
- C=4, send 0xA5: line reads 0,1,0,1,0,0,1,0,1,1, with each bit exactly 4 cycles. `tx_ready` goes high at A+41. `bit_tick` pulses 10 times.
- C=4, hold `tx_valid` high with 0x00 then 0xFF: two frames are accepted 41 cycles apart. `tx_data` changes during the first frame do not alter it.
- C=4, assert `reset` at A+13, mid-data: `tx`=1 and `tx_ready`=1 asynchronously. After release a new byte 0x3C transmits correctly.
- C=256, send 0x01: start bit lasts 256 cycles, the divider wraps without glitch, and the frame totals 2560 cycles.
- `UART_TX_PARITY_EN` defined, C=4: 0x07 gives parity bit 1 and 0x03 gives parity bit 0. Frame is 44 cycles and `tx_ready` goes high at A+45.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with an internal bit-period divider and a valid/ready byte input.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       bit_tick
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLKS_PER_BIT - 1);

  state_t     r_state;
  logic [7:0] r_div;
  logic [7:0] r_shift;
  logic [2:0] r_idx;
  logic       r_tx;

  state_t     w_state_nxt;
  logic [7:0] w_div_nxt;
  logic [7:0] w_shift_nxt;
  logic [2:0] w_idx_nxt;
  logic       w_tx_nxt;
  logic       w_tick;

`ifdef UART_TX_PARITY_EN
  logic r_par;
  logic w_par_nxt;
`endif

  // The divider only runs inside a frame, so the tick can never fire in IDLE.
  assign w_tick = (r_state != S_IDLE) && (r_div == DIV_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (r_state == S_IDLE) w_div_nxt = 8'd0;
    else                   w_div_nxt = w_tick ? 8'd0 : r_div + 8'd1;

    case (r_state)
      S_IDLE: begin
        if (tx_valid) begin
          w_state_nxt = S_START;
          w_shift_nxt = tx_data;
          w_idx_nxt   = 3'd0;
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = ^tx_data;
`endif
        end
      end
      S_START: if (w_tick) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_tick) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (w_tick) w_state_nxt = S_STOP;
`endif
      S_STOP: if (w_tick) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Line level is chosen from the next state so it can be registered.
    case (w_state_nxt)
      S_START:    w_tx_nxt = 1'b0;
      S_DATA:     w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY:   w_tx_nxt = w_par_nxt;
`endif
      default:    w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div   <= 8'd0;
      r_shift <= 8'd0;
      r_idx   <= 3'd0;
      r_tx    <= 1'b1;
    end else begin
      r_div   <= w_div_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_par <= 1'b0;
    else       r_par <= w_par_nxt;
  end
`endif

  assign tx       = r_tx;
  assign tx_ready = (r_state == S_IDLE);
  assign busy     = ~tx_ready;
  assign bit_tick = w_tick;

endmodule
